// File: rtl/pkt_channel_arbiter.sv
// Round-robin arbiter sharing one framed packet channel among NUM_REQ requesters.
// A grant is held from head to tail; a length watchdog truncates and flushes runaway packets.
module pkt_channel_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_head,
  input  logic [NUM_REQ-1:0]            req_tail,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic                          out_head,
  output logic                          out_tail,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          len_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_PKT_LEN - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MAX_PKT_LEN);

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusy  = 2'd1,
    ArbFlush = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                len_err_q, len_err_d;

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [IdxW-1:0]       cand;
  logic [NUM_REQ-1:0]    cand_req;
  logic                  sel_valid, sel_head, sel_tail;
  logic [DATA_WIDTH-1:0] sel_data;

  assign cand_req  = req_valid & req_head;
  assign sel_valid = req_valid[owner_q];
  assign sel_head  = req_head[owner_q];
  assign sel_tail  = req_tail[owner_q];
  assign sel_data  = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];

  // Search starts just after the last winner so every waiting head is served in turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + 32'd1 + 32'(k)) % NUM_REQ);
      if (!win_found && cand_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    len_err_d = 1'b0;
    req_ready = '0;
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      ArbIdle: begin
        if (win_found) begin
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        out_valid          = sel_valid;
        out_head           = sel_head;
        // The last allowed beat always closes the packet downstream.
        out_tail           = sel_tail | (cnt_q == LastBeat);
        out_data           = sel_data;
        req_ready[owner_q] = out_ready;
        if (sel_valid && out_ready) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (sel_tail) begin
            grant_d = '0;
            state_d = ArbIdle;
          end else if (cnt_q == LastBeat) begin
            grant_d   = '0;
            len_err_d = 1'b1;
            state_d   = ArbFlush;
          end
        end
      end
      ArbFlush: begin
        req_ready[owner_q] = 1'b1;
        if (sel_valid && sel_tail) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ArbIdle;
      owner_q   <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      len_err_q <= len_err_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == ArbBusy);
  assign len_err = len_err_q;

endmodule

// File: tb/tb_pkt_channel_arbiter.sv
// Directed table-driven bench for pkt_channel_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_PKT_LEN=4).
module tb_pkt_channel_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid, req_head, req_tail, req_ready;
  logic [31:0] req_data;
  logic        out_valid, out_head, out_tail, out_ready;
  logic [7:0]  out_data;
  logic [3:0]  grant;
  logic        busy, len_err;

  int checks   = 0;
  int failures = 0;

  pkt_channel_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_PKT_LEN(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_head (req_head),
    .req_tail (req_tail),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_head (out_head),
    .out_tail (out_tail),
    .out_data (out_data),
    .out_ready(out_ready),
    .grant    (grant),
    .busy     (busy),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v, h, t;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  rdy;
    logic        ov, oh, ot;
    logic [7:0]  od;
    logic        lerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                     input logic [31:0] d, input logic ordy, input logic [3:0] g,
                     input logic b, input logic [3:0] r, input logic ov, input logic oh,
                     input logic ot, input logic [7:0] od, input logic le);
    vec_t x;
    x.v = v; x.h = h; x.t = t; x.d = d; x.ordy = ordy;
    x.grant = g; x.busy = b; x.rdy = r; x.ov = ov; x.oh = oh; x.ot = ot; x.od = od;
    x.lerr = le;
    vecs.push_back(x);
  endtask

  // Inputs for a cycle where the arbiter is expected to sit in ARB_IDLE with all outputs low.
  task automatic add_idle(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                          input logic [31:0] d);
    add(v, h, t, d, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Round robin after reset: one-beat packets from all four, order 0,1,2,3,0.
    add_idle(4'hF, 4'hF, 4'hF, 32'h13121110);
    add(4'hF, 4'hF, 4'hF, 32'h13121110, 1, 4'b0001, 1, 4'b0001, 1, 1, 1, 8'h10, 0);
    add_idle(4'hF, 4'hF, 4'hF, 32'h13121110);
    add(4'hF, 4'hF, 4'hF, 32'h13121110, 1, 4'b0010, 1, 4'b0010, 1, 1, 1, 8'h11, 0);
    add_idle(4'hF, 4'hF, 4'hF, 32'h13121110);
    add(4'hF, 4'hF, 4'hF, 32'h13121110, 1, 4'b0100, 1, 4'b0100, 1, 1, 1, 8'h12, 0);
    add_idle(4'hF, 4'hF, 4'hF, 32'h13121110);
    add(4'hF, 4'hF, 4'hF, 32'h13121110, 1, 4'b1000, 1, 4'b1000, 1, 1, 1, 8'h13, 0);
    add_idle(4'hF, 4'hF, 4'hF, 32'h13121110);
    add(4'hF, 4'hF, 4'hF, 32'h13121110, 1, 4'b0001, 1, 4'b0001, 1, 1, 1, 8'h10, 0);
    add_idle(4'h0, 4'h0, 4'h0, 32'h0);
    // Single requester, 3-beat packet from req0.
    add_idle(4'b0001, 4'b0001, 4'h0, 32'h000000A1);
    add(4'b0001, 4'b0001, 4'h0, 32'h000000A1, 1, 4'b0001, 1, 4'b0001, 1, 1, 0, 8'hA1, 0);
    add(4'b0001, 4'h0, 4'h0, 32'h000000A2, 1, 4'b0001, 1, 4'b0001, 1, 0, 0, 8'hA2, 0);
    add(4'b0001, 4'h0, 4'b0001, 32'h000000A3, 1, 4'b0001, 1, 4'b0001, 1, 0, 1, 8'hA3, 0);
    add_idle(4'h0, 4'h0, 4'h0, 32'h0);
    // Stall: 4-beat packet from req2, out_ready 1,0,0,1,1,1.
    add_idle(4'b0100, 4'b0100, 4'h0, 32'h00B10000);
    add(4'b0100, 4'b0100, 4'h0, 32'h00B10000, 1, 4'b0100, 1, 4'b0100, 1, 1, 0, 8'hB1, 0);
    add(4'b0100, 4'h0, 4'h0, 32'h00B20000, 0, 4'b0100, 1, 4'b0000, 1, 0, 0, 8'hB2, 0);
    add(4'b0100, 4'h0, 4'h0, 32'h00B20000, 0, 4'b0100, 1, 4'b0000, 1, 0, 0, 8'hB2, 0);
    add(4'b0100, 4'h0, 4'h0, 32'h00B20000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0, 8'hB2, 0);
    add(4'b0100, 4'h0, 4'h0, 32'h00B30000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0, 8'hB3, 0);
    add(4'b0100, 4'h0, 4'b0100, 32'h00B40000, 1, 4'b0100, 1, 4'b0100, 1, 0, 1, 8'hB4, 0);
    add_idle(4'h0, 4'h0, 4'h0, 32'h0);
    // Watchdog: req1 sends 6 beats, 4th is force-tailed, 5-6 flushed.
    add_idle(4'b0010, 4'b0010, 4'h0, 32'h0000C100);
    add(4'b0010, 4'b0010, 4'h0, 32'h0000C100, 1, 4'b0010, 1, 4'b0010, 1, 1, 0, 8'hC1, 0);
    add(4'b0010, 4'h0, 4'h0, 32'h0000C200, 1, 4'b0010, 1, 4'b0010, 1, 0, 0, 8'hC2, 0);
    add(4'b0010, 4'h0, 4'h0, 32'h0000C300, 1, 4'b0010, 1, 4'b0010, 1, 0, 0, 8'hC3, 0);
    add(4'b0010, 4'h0, 4'h0, 32'h0000C400, 1, 4'b0010, 1, 4'b0010, 1, 0, 1, 8'hC4, 0);
    add(4'b0010, 4'h0, 4'h0, 32'h0000C500, 1, 4'b0000, 0, 4'b0010, 0, 0, 0, 8'h00, 1);
    add(4'b0010, 4'h0, 4'b0010, 32'h0000C600, 1, 4'b0000, 0, 4'b0010, 0, 0, 0, 8'h00, 0);
    add_idle(4'h0, 4'h0, 4'h0, 32'h0);
    // Non-interleave: req0 head arrives while req3 is mid-packet.
    add_idle(4'b1000, 4'b1000, 4'h0, 32'hD1000000);
    add(4'b1000, 4'b1000, 4'h0, 32'hD1000000, 1, 4'b1000, 1, 4'b1000, 1, 1, 0, 8'hD1, 0);
    add(4'b1001, 4'b0001, 4'b0001, 32'hD20000E1, 1, 4'b1000, 1, 4'b1000, 1, 0, 0, 8'hD2, 0);
    add(4'b1001, 4'b0001, 4'b1001, 32'hD30000E1, 1, 4'b1000, 1, 4'b1000, 1, 0, 1, 8'hD3, 0);
    add_idle(4'b0001, 4'b0001, 4'b0001, 32'h000000E1);
    add(4'b0001, 4'b0001, 4'b0001, 32'h000000E1, 1, 4'b0001, 1, 4'b0001, 1, 1, 1, 8'hE1, 0);
    add_idle(4'h0, 4'h0, 4'h0, 32'h0);

    reset = 1'b1;
    req_valid = '0; req_head = '0; req_tail = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", {23'd0, grant, busy, len_err, req_ready, out_valid},
        {23'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_valid = vecs[i].v; req_head = vecs[i].h; req_tail = vecs[i].t;
      req_data = vecs[i].d; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d", i),
          {11'd0, grant, busy, req_ready, out_valid, out_head, out_tail, out_data, len_err},
          {11'd0, vecs[i].grant, vecs[i].busy, vecs[i].rdy, vecs[i].ov, vecs[i].oh,
           vecs[i].ot, vecs[i].od, vecs[i].lerr});
    end

    // Reset during beat 2 of a req1 packet; afterwards req0 must beat req3.
    @(negedge clk);
    req_valid = 4'b0010; req_head = 4'b0010; req_tail = 4'h0; req_data = 32'h0000F100;
    out_ready = 1'b1;
    #1 chk("rst_pre_idle", {28'd0, grant}, 32'h0);
    @(negedge clk);
    #1 chk("rst_pre_grant", {28'd0, grant}, 32'h2);
    @(negedge clk);
    req_head = 4'h0; req_data = 32'h0000F200;
    #1 chk("rst_beat2", {24'd0, out_valid, busy, grant, out_data[1:0]}, {24'd0, 8'b1_1_0010_10});
    reset = 1'b1;
    #1 chk("rst_abort", {26'd0, grant, busy, out_valid}, 32'h0);
    chk("rst_abort_rdy", {28'd0, req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1001; req_head = 4'b1001; req_tail = 4'b1001; req_data = 32'h330000A0;
    #1 chk("rst_idle", {28'd0, grant}, 32'h0);
    @(negedge clk);
    #1 chk("rst_first_win", {20'd0, grant, out_data}, {20'd0, 4'b0001, 8'hA0});
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_channel_arbiter.md
# pkt_channel_arbiter

Round-robin arbiter that shares one packet channel among `NUM_REQ` requesters. Each requester sends framed packets using valid/head/tail beats, following the same IDLE→HEAD→DATA→TAIL framing as the channel FSMs. A grant is taken on a head beat and held until that requester's tail beat, so packets are never interleaved. A length watchdog drops runaway packets.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: payload width per beat.
- `MAX_PKT_LEN`, 16: maximum beats per packet, head and tail included (≥2).

Ports:
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_head` in NUM_REQ: beat is the first beat of a packet.
- `req_tail` in NUM_REQ: beat is the last beat of a packet. Head and tail may both be set for a one-beat packet.
- `req_data` in NUM_REQ*DATA_WIDTH: payloads; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out NUM_REQ: the beat offered by requester i is consumed this cycle.
- `out_valid`, `out_head`, `out_tail` out 1 each: channel beat and framing.
- `out_data` out DATA_WIDTH: channel payload.
- `out_ready` in 1: downstream accepts the beat.
- `grant` out NUM_REQ: one-hot owner of the channel (registered).
- `busy` out 1: a packet is in progress (registered).
- `len_err` out 1: one-cycle pulse when a packet is truncated (registered).

## Operation

States: `ARB_IDLE`, `ARB_BUSY`, `ARB_FLUSH`. State is encoded in 2 bits.

`ARB_IDLE`:
- All `req_ready` low. `out_valid` low.
- Candidates are requesters with `req_valid & req_head`.
- Winner is the first candidate at or after `(last_grant+1) mod NUM_REQ`.
- On a win: `grant` ← one-hot winner, `last_grant` ← winner, beat counter ← 0, next state `ARB_BUSY`.
- A valid beat without head is not a candidate. It stays stalled because its ready is low.

`ARB_BUSY` (granted requester g):
- `out_valid/head/tail/data` are a combinational pass-through of requester g. `req_ready[g] = out_ready`. All other readies are low.
- A beat transfers when `req_valid[g] & out_ready`. Each transfer increments the beat counter.
- Transfer with `req_tail[g]`: clear `grant` and `busy`, next state `ARB_IDLE`.
- Transfer number `MAX_PKT_LEN` without tail: that beat is still forwarded, but `out_tail` is forced to 1 on it so the downstream sees a closed packet. Then `len_err` pulses, `grant` clears, next state `ARB_FLUSH`.

`ARB_FLUSH` (g held internally, `grant` output reads 0):
- `out_valid` low. `req_ready[g]` high. g's beats are discarded.
- A discarded beat with `req_tail[g]` set → `ARB_IDLE`.

General rules:
- `busy` is 1 exactly in `ARB_BUSY`.
- The beat counter is `clog2(MAX_PKT_LEN+1)` bits and saturates. It never wraps.
- A head beat received mid-packet from g is forwarded as ordinary data; it does not restart the packet.

## Timing

- Reset values: `grant`=0, `busy`=0, `len_err`=0, all `req_ready`=0, `out_valid`=0. State is `ARB_IDLE` and `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-packet aborts immediately. No tail is emitted and the downstream must also be reset.
- Arbitration latency: a head presented in cycle N gets `grant` at edge N+1. The first beat can transfer in cycle N+1.
- Between packets there is exactly one `ARB_IDLE` bubble, including when the same requester sends back-to-back.
- The tail transfer and a new head from another requester in the same cycle: the new head is considered in the next `ARB_IDLE` cycle.
- `out_ready` low stalls g. Beats are held and the counter does not advance.
- `len_err` is asserted for the cycle after the truncating transfer.

## Test plan

- Single requester: req0 sends a 3-beat packet with `out_ready`=1 → `grant`=0001 one cycle after head. Beats appear on `out_*` with head/·/tail. `busy` is high for 3 cycles, then returns to IDLE.
- Round-robin: req0–3 all hold one-beat packets (head&tail) continuously → grant order 0,1,2,3,0, with one bubble between grants. No requester is granted twice before another waiting requester is served.
- Stall: 4-beat packet from req2, `out_ready` toggles 1,0,0,1,1,1 → exactly 4 transfers in order. `req_ready[2]` follows `out_ready`, and data is unchanged across stall cycles.
- Length watchdog with `MAX_PKT_LEN`=4: req1 sends 6 beats before its tail → 4 beats forwarded, the 4th with `out_tail`=1. `len_err` pulses once. Beats 5–6 are consumed with `out_valid`=0, then the arbiter returns to IDLE.
- Non-interleave: req3 mid-packet while req0 asserts head → `req_ready[0]` stays 0 until req3's tail transfers. req0 is granted one cycle after that.
- Reset mid-packet: assert `reset` during beat 2 of a packet from req1 → `grant`, `busy` and `out_valid` drop to 0 immediately. After release, requester 0 wins the first arbitration.
